// File: rtl/core_pkg.sv
// core_pkg: shared MEM-stage access encodings, FSM state type and access-size helpers.
package core_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
  localparam logic [2:0] OP_B  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_W  = 3'd2;
  localparam logic [2:0] OP_D  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;
  localparam logic [2:0] OP_HU = 3'd5;
  localparam logic [2:0] OP_WU = 3'd6;
  // log2 of the access width in bytes
  function automatic logic [1:0] op_size(input logic [2:0] op);
    return (op == OP_B || op == OP_BU) ? 2'd0 :
           (op == OP_H || op == OP_HU) ? 2'd1 :
           (op == OP_W || op == OP_WU) ? 2'd2 : 2'd3;
  endfunction
  function automatic logic is_signed(input logic [2:0] op);
    return op == OP_B || op == OP_H || op == OP_W || op == OP_D;
  endfunction
  function automatic logic misaligned(input logic [2:0] op, input logic [2:0] off);
    logic [1:0] s;
    s = op_size(op);
    return s == 2'd0 ? 1'b0 : s == 2'd1 ? off[0] : s == 2'd2 ? |off[1:0] : |off;
  endfunction
  function automatic logic [7:0] base_strb(input logic [2:0] op);
    logic [1:0] s;
    s = op_size(op);
    return s == 2'd0 ? 8'h01 : s == 2'd1 ? 8'h03 : s == 2'd2 ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: shifts the addressed bytes of a read doubleword down and sign/zero-extends them.
module load_align
  import core_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_op,
  output logic [63:0] o_data
);
  logic [63:0] w_sh;
  logic [1:0]  w_sz;
  logic        w_sg;
  assign w_sh = i_rdata >> {i_off, 3'b000};
  assign w_sz = op_size(i_op);
  assign w_sg = is_signed(i_op);
  assign o_data = w_sz == 2'd0 ? {{56{w_sg & w_sh[7]}}, w_sh[7:0]} :
                  w_sz == 2'd1 ? {{48{w_sg & w_sh[15]}}, w_sh[15:0]} :
                  w_sz == 2'd2 ? {{32{w_sg & w_sh[31]}}, w_sh[31:0]} : w_sh;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage; registers execute results, runs load/store requests
// over a valid/ready memory port and emits a one-cycle writeback pulse plus forwarding.
module mem_access_stage
  import core_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_aluresult,
  input  logic [DATA_W-1:0] ex_rs2,
  input  logic [5:0]        ex_rd,
  input  logic              ex_mem_active,
  input  logic              ex_load,
  input  logic              ex_wbactive,
  input  logic [2:0]        ex_mem_op,
  output logic              mem_stall,
  output logic [5:0]        fwd_rd,
  output logic [DATA_W-1:0] fwd_rdval,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              wb_valid,
  output logic [5:0]        wb_rd,
  output logic [DATA_W-1:0] wb_rdval,
  output logic              wb_wbactive,
  output logic              misalign_err
);
  mem_state_t        r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rs2, r_wb_rdval;
  logic [5:0]        r_rd, r_wb_rd;
  logic [2:0]        r_op;
  logic              r_load, r_wb_valid, r_wb_act, r_mis;
  logic              w_cap, w_mis, w_req;
  logic [2:0]        w_off;
  logic [DATA_W-1:0] w_load_data;
  assign w_cap = r_state == IDLE && ex_valid;
  assign w_mis = ex_mem_active && misaligned(ex_mem_op, ex_aluresult[2:0]);
  assign w_off = r_addr[2:0];
  load_align u_align (
    .i_rdata(mem_resp_rdata),
    .i_off  (w_off),
    .i_op   (r_op),
    .o_data (w_load_data)
  );
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? ((w_cap && ex_mem_active && !w_mis) ? REQ : IDLE) :
             r_state == REQ  ? (mem_req_ready ? RESP : REQ) :
                               (mem_resp_valid ? IDLE : RESP);
  always_comb begin
    w_req         = r_state == REQ;
    mem_stall     = r_state != IDLE;
    mem_req_valid = w_req;
    mem_req_we    = w_req && !r_load;
    mem_req_addr  = w_req ? {r_addr[ADDR_W-1:3], 3'b000} : '0;
    mem_req_wstrb = mem_req_we ? base_strb(r_op) << w_off : '0;
    mem_req_wdata = mem_req_we ? r_rs2 << {w_off, 3'b000} : '0;
  end
  always_ff @(posedge clk)
    if (w_cap) begin
      r_addr <= ex_aluresult;
      r_rs2  <= ex_rs2;
      r_rd   <= ex_rd;
      r_load <= ex_load;
      r_op   <= ex_mem_op;
    end
  // Writeback fields hold between pulses so forwarding keeps seeing the last result.
  always_ff @(posedge clk)
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_act   <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_rdval <= '0;
      r_mis      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_mis      <= 1'b0;
      if (w_cap && (!ex_mem_active || w_mis)) begin
        r_wb_valid <= 1'b1;
        r_mis      <= w_mis;
        r_wb_act   <= ex_wbactive && !ex_mem_active;
        r_wb_rd    <= ex_rd;
        if (!ex_mem_active) r_wb_rdval <= ex_aluresult;
      end else if (r_state == RESP && mem_resp_valid) begin
        r_wb_valid <= 1'b1;
        r_wb_act   <= r_load;
        r_wb_rd    <= r_rd;
        if (r_load) r_wb_rdval <= w_load_data;
      end
    end
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_rdval     = r_wb_rdval;
  assign wb_wbactive  = r_wb_act;
  assign misalign_err = r_mis;
  assign fwd_rd       = r_wb_act ? r_wb_rd : 6'd0;
  assign fwd_rdval    = r_wb_rdval;
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage between execute and writeback. It registers the execute-stage result, performs load/store accesses over a valid/ready request, valid-only response data-memory port, and extracts and extends load data. It drives the forwarding value and stall back to execute and a one-cycle writeback packet forward.

## Interface
Parameters:
- ADDR_W, 64, address width; only 64 is supported.
- DATA_W, 64, memory data width; only 64 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  execute output is valid this cycle.
- ex_aluresult  in  64  ALU result, or effective address for memory ops.
- ex_rs2  in  64  store data.
- ex_rd  in  6  destination register.
- ex_mem_active  in  1  op is a load or store.
- ex_load  in  1  1 = load, 0 = store (meaningful only with ex_mem_active).
- ex_wbactive  in  1  op writes a register.
- ex_mem_op  in  3  access type: 0 lb/sb, 1 lh/sh, 2 lw/sw, 3 ld/sd, 4 lbu, 5 lhu, 6 lwu.
- mem_stall  out  1  execute must hold its outputs.
- fwd_rd  out  6  forwarding destination; 0 when no write is pending.
- fwd_rdval  out  64  forwarding value.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  64  8-byte-aligned address.
- mem_req_we  out  1  1 = write.
- mem_req_wdata  out  64  lane-aligned write data.
- mem_req_wstrb  out  8  byte enables.
- mem_resp_valid  in  1  read data returned, or write acknowledged.
- mem_resp_rdata  in  64  read data.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  6  writeback destination.
- wb_rdval  out  64  writeback value.
- wb_wbactive  out  1  writeback enable.
- misalign_err  out  1  one-cycle pulse on a misaligned access.

## Operation
- FSM states: IDLE, REQ, RESP.
- mem_stall = (state != IDLE), combinational.
- Capture: in IDLE with ex_valid=1, latch all ex_* inputs.
- Non-memory op: stay in IDLE. Next cycle drives wb_valid=1, wb_rd=ex_rd, wb_rdval=ex_aluresult, wb_wbactive=ex_wbactive.
- Memory op, aligned: go to REQ. Offset off = addr[2:0].
  - mem_req_addr = {addr[63:3], 3'b0}.
  - Store: wstrb = (1/3/15/255 for b/h/w/d) << off; wdata = rs2 << (8*off).
- Alignment rule: h needs off[0]=0; w needs off[1:0]=0; d needs off=0.
- Misaligned: issue no request and stay in IDLE. Next cycle drives misalign_err=1, wb_valid=1, wb_wbactive=0.
- REQ: hold mem_req_valid=1 and all request fields stable until mem_req_ready=1, then go to RESP. Request outputs are 0 outside REQ.
- RESP: wait for mem_resp_valid, then return to IDLE.
  - Load: data = rdata >> (8*off). Truncate to the access width, then sign-extend (ops 0–3) or zero-extend (4–6). Drive wb_valid=1, wb_rdval=data, wb_wbactive=1.
  - Store: drive wb_valid=1, wb_wbactive=0.
- fwd_rd = wb_wbactive ? wb_rd : 0; fwd_rdval = wb_rdval.
  - Writeback outputs hold their last values when wb_valid=0, so forwarding persists.
- Ignored inputs:
  - mem_resp_valid in IDLE or REQ.
  - ex_valid while mem_stall=1; execute holds its outputs.

## Timing
- Reset: state=IDLE. mem_req_valid, mem_req_we, mem_req_wstrb, wb_valid, wb_wbactive, misalign_err, wb_rd and fwd_rd are 0. wb_rdval, fwd_rdval, mem_req_addr and mem_req_wdata are 0.
- Reset mid-access: abandon the request and enter IDLE the next cycle. A late mem_resp_valid is ignored.
- Non-memory latency: 1 cycle from capture edge to wb_valid.
- Memory latency: capture edge N; REQ during cycle N+1. With req_ready=1 and resp_valid one cycle later, wb_valid appears at cycle N+3.
- mem_stall is high for the whole of REQ and RESP.
- The cycle wb_valid rises, mem_stall is already 0, so a new capture can occur back-to-back.
- Simultaneous mem_req_ready and mem_resp_valid in REQ: the response is ignored; the memory must respond at least one cycle after acceptance.

## Structure
- Shared package (core_pkg): mem_op encoding constants; mem_state_t enum.
- One sub-module, load_align: combinational byte-shift and sign/zero extension, rdata + off + mem_op → 64-bit value.

## Test plan
- addi result 0x2A to rd=5 with ex_valid -> next cycle wb_valid=1, wb_rd=5, wb_rdval=0x2A, fwd_rd=5, no request issued.
- lb addr 0x1003, rdata 0x00000000_80000000 -> addr=0x1000, wb_rdval=0xFFFF_FFFF_FFFF_FF80. Same access as lbu -> 0x80.
- sh addr 0x2006, rs2=0xBEEF -> wstrb=0xC0, wdata[63:48]=0xBEEF, we=1. After resp_valid: wb_valid=1, wb_wbactive=0.
- lw addr 0x3002 -> misalign_err=1 for one cycle, no mem_req_valid, wb_wbactive=0.
- mem_req_ready low 3 cycles, then high -> request fields stable throughout, mem_stall=1 until resp_valid, exactly one wb_valid.
- reset asserted during RESP, then resp_valid -> state IDLE, wb_valid stays 0, all outputs at reset values.
